inv_cipher_iter: RTL

- Iterative, multi-key-size AES inverse cipher: one 128-bit block per transaction, key size selected per block (AES-128/192/256).
- Executes ROUNDS_PER_CYCLE inverse rounds per clock over a registered state, replacing the fully unrolled combinational inverse cipher.
- Sits between the decryption key-expansion output (full round-key schedule) and the plaintext consumer.
- Uses valid/ready handshakes on input and output.

---
 rtl/inv_cipher_iter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher for 128/192/256-bit keys.
// A 128-bit ciphertext block and its full round-key schedule are captured in
// one handshake. ROUNDS_PER_CYCLE inverse rounds are then applied per clock
// over a registered state, and the plaintext is offered on a valid/ready
// output port.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is high only in IDLE)
//   in_data [127:0]     ciphertext block
//   size [1:0]          00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_out             round keys; rk[j] = key_out[128*(j+1)-1 -: 128]
//   out_valid/out_ready output handshake
//   out_data [127:0]    plaintext block
//   out_err             size was illegal or unsupported (qualified by out_valid)
//   busy                high while a block is in ROUND or DONE
module inv_cipher_iter #(
  parameter int NK_MAX           = 8,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [127:0]                 in_data,
  input  logic [1:0]                   size,
  input  logic [128*(NK_MAX+7)-1:0]    key_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_data,
  output logic                         out_err,
  output logic                         busy
);

  localparam int         NR_MAX   = NK_MAX + 6;
  localparam int         RPC      = ROUNDS_PER_CYCLE;
  localparam logic [3:0] NR_MAX_L = 4'(NR_MAX);
  localparam logic [3:0] RPC_L    = 4'(RPC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } st_e;

  st_e          st_r, st_nxt_s;
  logic [127:0] blk_r;
  logic [3:0]   rnd_r;
  logic [127:0] rk_r [0:NR_MAX];
  logic [127:0] out_data_r;
  logic         out_err_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;

  logic [3:0]   nr_s;
  logic         bad_s;
  logic [127:0] rk_top_s;
  logic [127:0] rnd_blk_s;
  logic [3:0]   rnd_idx_s;
  logic [3:0]   rk_idx_s;
  logic         rnd_fin_s;

  // ---------------------------------------------------------------------
  // GF(2^8) and inverse-round helpers
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte k of a block sits at [127-8k -: 8]; byte 4c+r is row r, column c.
  // InvShiftRows moves row r right by r, so output (r,c) reads input (r,c-r).
  function automatic logic [127:0] inv_round(input logic [127:0] blk,
                                             input logic [127:0] rk,
                                             input logic         mix);
    logic [127:0] t;
    t = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = inv_sbox(blk[127-8*(4*((c+4-r)%4)+r) -: 8])
                                ^ rk[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      t[127-32*c -: 32] = mix ? inv_mix_col(t[127-32*c -: 32]) : t[127-32*c -: 32];
    end
    return t;
  endfunction

  // Decode key size into round count and supported flag, and pick rk[Nr].
  always_comb begin
    nr_s     = 4'd0;
    rk_top_s = 128'd0;
    case (size)
      2'b00:   nr_s = 4'd10;
      2'b01:   nr_s = 4'd12;
      2'b10:   nr_s = 4'd14;
      default: nr_s = 4'd0;
    endcase
    bad_s = (size == 2'b11) || (nr_s > NR_MAX_L);
    for (int j = 0; j <= NR_MAX; j++) begin
      if (4'(j) == nr_s) begin
        rk_top_s = key_out[128*j +: 128];
      end else begin
        rk_top_s = rk_top_s;
      end
    end
  end

  // Chain ROUNDS_PER_CYCLE inverse rounds starting at round index rnd_r.
  always_comb begin
    rnd_blk_s = blk_r;
    rnd_idx_s = rnd_r;
    rk_idx_s  = 4'd0;
    for (int k = 0; k < RPC; k++) begin
      rk_idx_s  = (rnd_idx_s > NR_MAX_L) ? 4'd0 : rnd_idx_s;
      rnd_blk_s = inv_round(rnd_blk_s, rk_r[rk_idx_s], rnd_idx_s != 4'd0);
      rnd_idx_s = rnd_idx_s - 4'd1;
    end
    // The group of rounds ending at index 0 is the last one.
    rnd_fin_s = (rnd_r == RPC_L - 4'd1);
  end

  // Next-state logic.
  always_comb begin
    st_nxt_s = st_r;
    case (st_r)
      ST_IDLE: begin
        if (in_valid) begin
          st_nxt_s = bad_s ? ST_DONE : ST_ROUND;
        end else begin
          st_nxt_s = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (rnd_fin_s) begin
          st_nxt_s = ST_DONE;
        end else begin
          st_nxt_s = ST_ROUND;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          st_nxt_s = ST_IDLE;
        end else begin
          st_nxt_s = ST_DONE;
        end
      end
      default: st_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  // out_valid trails entry into DONE by one clock so the result register has
  // settled before it is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r        <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      st_r        <= st_nxt_s;
      in_ready_r  <= (st_nxt_s == ST_IDLE);
      out_valid_r <= (st_r == ST_DONE) && (st_nxt_s == ST_DONE);
      busy_r      <= (st_nxt_s != ST_IDLE);
    end
  end

  // Datapath: capture block and keys, iterate rounds, load the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_r      <= 128'd0;
      rnd_r      <= 4'd0;
      out_data_r <= 128'd0;
      out_err_r  <= 1'b0;
      for (int j = 0; j <= NR_MAX; j++) begin
        rk_r[j] <= 128'd0;
      end
    end else begin
      case (st_r)
        ST_IDLE: begin
          if (in_valid) begin
            // Keys above Nr are captured too but never indexed.
            for (int j = 0; j <= NR_MAX; j++) begin
              rk_r[j] <= key_out[128*j +: 128];
            end
            if (bad_s) begin
              out_data_r <= 128'd0;
              out_err_r  <= 1'b1;
            end else begin
              blk_r <= in_data ^ rk_top_s;
              rnd_r <= nr_s - 4'd1;
            end
          end
        end
        ST_ROUND: begin
          blk_r <= rnd_blk_s;
          rnd_r <= rnd_r - RPC_L;
          if (rnd_fin_s) begin
            out_data_r <= rnd_blk_s;
            out_err_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          blk_r <= blk_r;
        end
        default: begin
          blk_r <= blk_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign busy      = busy_r;

endmodule
